// File: rtl/writeback_queue.sv
// writeback_queue: circular FIFO that buffers register-file writes and drains
// one entry per cycle into a registered write port. Pending writes, including
// the one in the output register, are forwarded to two read ports.
//
// Ports:
//   clk, reset              clock and synchronous active-high reset
//   in_valid/in_ready       producer handshake; in_addr/in_data write request
//   wb_hold                 stalls draining while high
//   RegWrite/WriteAddr/
//   WriteData               registered register-file write port
//   ReadAddr1/ReadAddr2     register-file read addresses to snoop
//   hit1/hit2,
//   BypassData1/BypassData2 combinational forwarding results
//   count                   number of queued entries (output register excluded)
module writeback_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_addr,
    input  logic [31:0] in_data,
    input  logic        wb_hold,
    output logic        RegWrite,
    output logic [4:0]  WriteAddr,
    output logic [31:0] WriteData,
    input  logic [4:0]  ReadAddr1,
    input  logic [4:0]  ReadAddr2,
    output logic        hit1,
    output logic        hit2,
    output logic [31:0] BypassData1,
    output logic [31:0] BypassData2,
    output logic [3:0]  count
);

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              regwrite_q, regwrite_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              push;
    logic              pop;
    logic [PTR_W-1:0]  byp_idx;

    // Handshake: a write to register 0 completes the handshake but is dropped.
    assign in_ready = (count_q < CNT_W'(DEPTH)) && !reset;
    assign push     = in_valid && in_ready && (in_addr != '0);
    assign pop      = (count_q != '0) && !wb_hold;

    // Next-state: pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        addr_d     = addr_q;
        data_d     = data_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        regwrite_d = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;

        if (pop) begin
            head_d     = head_q + PTR_W'(1);
            regwrite_d = 1'b1;
            waddr_d    = addr_q[head_q];
            wdata_d    = data_q[head_q];
        end

        if (push) begin
            addr_d[tail_q] = in_addr;
            data_d[tail_q] = in_data;
            tail_d         = tail_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset wins over any concurrent push or pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= '{default: '0};
            data_q     <= '{default: '0};
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            regwrite_q <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            addr_q     <= addr_d;
            data_q     <= data_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            regwrite_q <= regwrite_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    // Forwarding: output register is the oldest candidate; queued entries are
    // scanned oldest to youngest so the youngest match overrides.
    always_comb begin
        hit1        = 1'b0;
        hit2        = 1'b0;
        BypassData1 = '0;
        BypassData2 = '0;
        byp_idx     = head_q;

        if (ReadAddr1 != '0 && regwrite_q && waddr_q == ReadAddr1) begin
            hit1        = 1'b1;
            BypassData1 = wdata_q;
        end
        if (ReadAddr2 != '0 && regwrite_q && waddr_q == ReadAddr2) begin
            hit2        = 1'b1;
            BypassData2 = wdata_q;
        end

        for (int unsigned i = 0; i < DEPTH; i++) begin
            byp_idx = head_q + PTR_W'(i);
            if (CNT_W'(i) < count_q) begin
                if (ReadAddr1 != '0 && addr_q[byp_idx] == ReadAddr1) begin
                    hit1        = 1'b1;
                    BypassData1 = data_q[byp_idx];
                end
                if (ReadAddr2 != '0 && addr_q[byp_idx] == ReadAddr2) begin
                    hit2        = 1'b1;
                    BypassData2 = data_q[byp_idx];
                end
            end
        end
    end

    assign RegWrite  = regwrite_q;
    assign WriteAddr = waddr_q;
    assign WriteData = wdata_q;
    assign count     = count_q;

endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a queue-based model.
module tb_writeback_queue;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_addr;
    logic [31:0] in_data;
    logic        wb_hold;
    logic        RegWrite;
    logic [4:0]  WriteAddr;
    logic [31:0] WriteData;
    logic [4:0]  ReadAddr1;
    logic [4:0]  ReadAddr2;
    logic        hit1;
    logic        hit2;
    logic [31:0] BypassData1;
    logic [31:0] BypassData2;
    logic [3:0]  count;

    always #5 clk = ~clk;

    writeback_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .wb_hold    (wb_hold),
        .RegWrite   (RegWrite),
        .WriteAddr  (WriteAddr),
        .WriteData  (WriteData),
        .ReadAddr1  (ReadAddr1),
        .ReadAddr2  (ReadAddr2),
        .hit1       (hit1),
        .hit2       (hit2),
        .BypassData1(BypassData1),
        .BypassData2(BypassData2),
        .count      (count)
    );

    // Reference model: a plain queue of pending writes plus the last write.
    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    logic        m_rw;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    function automatic logic [32:0] m_bypass(input logic [4:0] ra);
        logic        h;
        logic [31:0] d;
        h = 1'b0;
        d = '0;
        if (ra != 0) begin
            if (m_rw && m_wa == ra) begin
                h = 1'b1;
                d = m_wd;
            end
            foreach (mq[i]) begin
                if (mq[i].a == ra) begin
                    h = 1'b1;
                    d = mq[i].d;
                end
            end
        end
        return {h, d};
    endfunction

    task automatic model_edge();
        bit   do_pop;
        bit   do_push;
        ent_t e;
        if (reset) begin
            mq.delete();
            m_rw = 1'b0;
            m_wa = '0;
            m_wd = '0;
        end else begin
            do_pop  = (mq.size() > 0) && !wb_hold;
            do_push = in_valid && (mq.size() < DEPTH) && (in_addr != 0);
            if (do_pop) begin
                e    = mq.pop_front();
                m_rw = 1'b1;
                m_wa = e.a;
                m_wd = e.d;
            end else begin
                m_rw = 1'b0;
            end
            if (do_push) mq.push_back('{a: in_addr, d: in_data});
        end
    endtask

    task automatic check_model();
        logic [32:0] b1;
        logic [32:0] b2;
        b1 = m_bypass(ReadAddr1);
        b2 = m_bypass(ReadAddr2);
        chk("in_ready", 32'(in_ready), 32'((mq.size() < DEPTH) && !reset));
        chk("count", 32'(count), 32'(mq.size()));
        chk("RegWrite", 32'(RegWrite), 32'(m_rw));
        chk("WriteAddr", 32'(WriteAddr), 32'(m_wa));
        chk("WriteData", WriteData, m_wd);
        chk("hit1", 32'(hit1), 32'(b1[32]));
        chk("BypassData1", BypassData1, b1[31:0]);
        chk("hit2", 32'(hit2), 32'(b2[32]));
        chk("BypassData2", BypassData2, b2[31:0]);
    endtask

    // One cycle: check the current cycle, pass the edge, land on the negedge.
    task automatic step();
        #1;
        check_model();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive(input logic r, input logic v, input logic [4:0] a,
                         input logic [31:0] d, input logic h);
        reset    = r;
        in_valid = v;
        in_addr  = a;
        in_data  = d;
        wb_hold  = h;
    endtask

    typedef struct {
        logic        v;
        logic [4:0]  a;
        logic [31:0] d;
        logic        hold;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [3:0]  e_cnt;
        logic        e_rw;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_h1;
        logic [31:0] e_b1;
        logic        e_h2;
        logic [31:0] e_b2;
    } vec_t;

    vec_t vecs[11];

    initial begin
        // Expected outputs are those seen in the cycle after the vector's edge.
        vecs[0]  = '{1'b1, 5'd5, 32'hAA,       1'b0, 5'd5, 5'd0, 4'd1, 1'b0, 5'd0, 32'h0,  1'b1, 32'hAA, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd5, 5'd0, 4'd0, 1'b1, 5'd5, 32'hAA, 1'b1, 32'hAA, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd5, 5'd0, 4'd0, 1'b0, 5'd5, 32'hAA, 1'b0, 32'h0,  1'b0, 32'h0};
        vecs[3]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0, 4'd0, 1'b0, 5'd5, 32'hAA, 1'b0, 32'h0,  1'b0, 32'h0};
        vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 4'd0, 1'b0, 5'd5, 32'hAA, 1'b0, 32'h0,  1'b0, 32'h0};
        vecs[5]  = '{1'b1, 5'd7, 32'h11,       1'b1, 5'd7, 5'd8, 4'd1, 1'b0, 5'd5, 32'hAA, 1'b1, 32'h11, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 5'd7, 32'h22,       1'b1, 5'd7, 5'd8, 4'd2, 1'b0, 5'd5, 32'hAA, 1'b1, 32'h22, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd8, 4'd2, 1'b0, 5'd5, 32'hAA, 1'b1, 32'h22, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd7, 5'd8, 4'd1, 1'b1, 5'd7, 32'h11, 1'b1, 32'h22, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd7, 5'd8, 4'd0, 1'b1, 5'd7, 32'h22, 1'b1, 32'h22, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd7, 5'd8, 4'd0, 1'b0, 5'd7, 32'h22, 1'b0, 32'h0,  1'b0, 32'h0};

        m_rw = 1'b0;
        m_wa = '0;
        m_wd = '0;
        ReadAddr1 = '0;
        ReadAddr2 = '0;
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0);

        // Reset state
        @(negedge clk);
        #1;
        chk("ready_in_reset", 32'(in_ready), 32'd0);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_regwrite", 32'(RegWrite), 32'd0);
        chk("rst_waddr", 32'(WriteAddr), 32'd0);
        chk("rst_wdata", WriteData, 32'd0);
        step();

        // First cycle after reset release
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        ReadAddr1 = 5'd3;
        ReadAddr2 = 5'd4;
        #1;
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        chk("post_rst_hit1", 32'(hit1), 32'd0);
        chk("post_rst_hit2", 32'(hit2), 32'd0);
        chk("post_rst_regwrite", 32'(RegWrite), 32'd0);
        step();

        // Directed vector table
        for (int i = 0; i < 11; i++) begin
            drive(1'b0, vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].hold);
            ReadAddr1 = vecs[i].r1;
            ReadAddr2 = vecs[i].r2;
            step();
            #1;
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
            chk($sformatf("vec%0d_rw", i), 32'(RegWrite), 32'(vecs[i].e_rw));
            chk($sformatf("vec%0d_wa", i), 32'(WriteAddr), 32'(vecs[i].e_wa));
            chk($sformatf("vec%0d_wd", i), WriteData, vecs[i].e_wd);
            chk($sformatf("vec%0d_hit1", i), 32'(hit1), 32'(vecs[i].e_h1));
            chk($sformatf("vec%0d_byp1", i), BypassData1, vecs[i].e_b1);
            chk($sformatf("vec%0d_hit2", i), 32'(hit2), 32'(vecs[i].e_h2));
            chk($sformatf("vec%0d_byp2", i), BypassData2, vecs[i].e_b2);
        end

        // Fill to full under hold, reject a fifth push, then drain; three laps wrap pointers
        ReadAddr1 = '0;
        ReadAddr2 = '0;
        for (int rep = 0; rep < 3; rep++) begin
            for (int k = 1; k <= 4; k++) begin
                drive(1'b0, 1'b1, 5'(k), 32'(k * 256 + rep), 1'b1);
                step();
            end
            #1;
            chk("fill_count", 32'(count), 32'd4);
            chk("fill_ready", 32'(in_ready), 32'd0);
            drive(1'b0, 1'b1, 5'd9, 32'hDEAD, 1'b1);
            step();
            #1;
            chk("fifth_ignored", 32'(count), 32'd4);
            drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
            for (int k = 1; k <= 4; k++) begin
                step();
                #1;
                chk("drain_rw", 32'(RegWrite), 32'd1);
                chk("drain_addr", 32'(WriteAddr), 32'(k));
                chk("drain_data", WriteData, 32'(k * 256 + rep));
            end
            step();
            #1;
            chk("drain_done_rw", 32'(RegWrite), 32'd0);
            chk("drain_done_count", 32'(count), 32'd0);
        end

        // Concurrent push and pop at count 2
        drive(1'b0, 1'b1, 5'd10, 32'h100, 1'b1);
        step();
        drive(1'b0, 1'b1, 5'd11, 32'h101, 1'b1);
        step();
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 1'b1, 5'(12 + k), 32'(32'h200 + k), 1'b0);
            step();
            #1;
            chk("conc_count", 32'(count), 32'd2);
            chk("conc_rw", 32'(RegWrite), 32'd1);
        end
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        for (int k = 0; k < 3; k++) step();

        // Reset in the middle of a drain, with a push offered on the reset edge
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b1, 5'(20 + k), 32'(32'h300 + k), 1'b1);
            step();
        end
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        step();
        #1;
        chk("mid_count", 32'(count), 32'd3);
        chk("mid_rw", 32'(RegWrite), 32'd1);
        chk("mid_addr", 32'(WriteAddr), 32'd20);
        drive(1'b1, 1'b1, 5'd24, 32'h400, 1'b0);
        step();
        #1;
        chk("rst_mid_count", 32'(count), 32'd0);
        chk("rst_mid_rw", 32'(RegWrite), 32'd0);
        chk("rst_mid_wa", 32'(WriteAddr), 32'd0);
        chk("rst_mid_wd", WriteData, 32'd0);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        ReadAddr1 = 5'd21;
        #1;
        chk("rst_mid_ready", 32'(in_ready), 32'd1);
        chk("rst_mid_hit1", 32'(hit1), 32'd0);
        for (int k = 0; k < 6; k++) begin
            step();
            #1;
            chk("rst_mid_no_write", 32'(RegWrite), 32'd0);
        end

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            drive(($urandom % 64) == 0, $urandom % 4 != 0, 5'($urandom % 8),
                  $urandom, ($urandom % 3) == 0);
            ReadAddr1 = 5'($urandom % 8);
            ReadAddr2 = 5'($urandom % 8);
            step();
        end
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        for (int k = 0; k < 6; k++) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, meaning the number of queued write requests; legal values are 2, 4 and 8.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-004 The module SHALL have port in_valid, input, 1, meaning a producer write request is present.
REQ-005 The module SHALL have port in_ready, output, 1, meaning the queue accepts a request this cycle.
REQ-006 The module SHALL have port in_addr, input, 5, the destination register number.
REQ-007 The module SHALL have port in_data, input, 32, the signed value to write.
REQ-008 The module SHALL have port wb_hold, input, 1, which suppresses draining while high.
REQ-009 The module SHALL have port RegWrite, output, 1, the register-file write enable.
REQ-010 The module SHALL have port WriteAddr, output, 5, the register-file write address.
REQ-011 The module SHALL have port WriteData, output, 32, the register-file write data.
REQ-012 The module SHALL have ports ReadAddr1 and ReadAddr2, input, 5 each, mirroring the register-file read addresses.
REQ-013 The module SHALL have ports hit1 and hit2, output, 1 each, meaning a pending write targets the corresponding read address.
REQ-014 The module SHALL have ports BypassData1 and BypassData2, output, 32 each, carrying the forwarded value.
REQ-015 The module SHALL have port count, output, 4, the number of queued entries, excluding the output register.

Function
REQ-016 The queue SHALL be a circular FIFO with DEPTH entries of {addr[4:0], data[31:0]} and head/tail pointers that wrap modulo DEPTH.
REQ-017 in_ready SHALL equal (count < DEPTH) and !reset, as a combinational function with no full-cycle pass-through.
REQ-018 A push SHALL occur at an edge where in_valid and in_ready are both high and in_addr != 0.
REQ-019 A request with in_addr == 0 SHALL be accepted, which consumes the handshake, and discarded, leaving count unchanged.
REQ-020 When in_valid is high and in_ready is low, the request SHALL be ignored, and the producer holds it.
REQ-021 A pop SHALL occur at an edge where count > 0 (the value before the edge) and wb_hold is low.
REQ-022 On a pop, the output register SHALL load the head entry and set RegWrite=1 for exactly the following cycle.
REQ-023 On an edge with no pop, RegWrite SHALL be 0, while WriteAddr and WriteData keep their last values.
REQ-024 Throughput SHALL be one drain per cycle.
REQ-025 Latency from an accepting edge k into an empty queue with wb_hold low SHALL be: pop at edge k+1, RegWrite high in cycle k+1..k+2, and register file updated at edge k+2.
REQ-026 On a simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-027 On a push only, count SHALL increase by 1; on a pop only, count SHALL decrease by 1; count SHALL never exceed DEPTH or go below 0.
REQ-028 Drain order SHALL be strict FIFO order of accepted requests.
REQ-029 The bypass for port n SHALL be combinational.
REQ-030 hitn SHALL be 1 when ReadAddrn != 0 and either a queued entry or the output register with RegWrite=1 has addr == ReadAddrn.
REQ-031 BypassDatan SHALL take the data of the youngest matching queued entry, else the output register data, else 0.
REQ-032 When ReadAddrn == 0, hitn SHALL be 0 and BypassDatan SHALL be 0.
REQ-033 A push at an edge SHALL become visible to bypass in the following cycle and not in the same cycle.
REQ-034 wb_hold SHALL not affect acceptance; the queue keeps filling until full.

Reset
REQ-035 At an edge where reset is high, count, head, tail, RegWrite, WriteAddr and WriteData SHALL all clear to 0, and in_ready SHALL read 0 during reset.
REQ-036 Reset asserted mid-operation SHALL discard all pending entries with no further RegWrite pulse, and it takes priority over simultaneous push or pop.
REQ-037 In the first cycle after reset deasserts, in_ready SHALL be 1, hit1 and hit2 SHALL be 0, and RegWrite SHALL be 0.

Verification
REQ-038 Single write: push (addr=5, data=0x0000_00AA) at edge k with wb_hold=0 -> RegWrite=1, WriteAddr=5, WriteData=0xAA in cycle k+1..k+2 only, and count returns to 0.
REQ-039 Fill and wrap: with wb_hold=1 push addresses 1,2,3,4 -> count=4 and in_ready=0; a 5th push is ignored; release wb_hold -> four consecutive RegWrite pulses with addresses 1,2,3,4; repeat 3 times so the pointers wrap.
REQ-040 Register zero: push (addr=0, data=0xFFFF_FFFF) -> handshake completes, count stays 0, and RegWrite never asserts.
REQ-041 Bypass priority: with wb_hold=1 push (7,0x11) then (7,0x22), set ReadAddr1=7 -> hit1=1 and BypassData1=0x22; set ReadAddr2=8 -> hit2=0 and BypassData2=0.
REQ-042 Concurrent push and pop: with count=2 and wb_hold=0, push on every cycle -> count stays 2 and RegWrite is high on every cycle.
REQ-043 Reset mid-drain: with count=3 and RegWrite=1, assert reset for one edge -> next cycle count=0, RegWrite=0, WriteAddr=0, WriteData=0, and no queued address is ever written.
